// File: rtl/cache_fill_arbiter.sv
// Cache fill arbiter: picks an I- or D-cache miss, fetches the block as WORDS
// 16-bit words from pipelined memory, streams them into the cache, then writes the tag.
// Optional: define ARB_ROUND_ROBIN_EN for round-robin tie breaking (default: D has fixed priority).
module cache_fill_arbiter #(
    parameter int WORDS = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_miss,
    input  logic [15:0]                i_addr,
    input  logic                       d_miss,
    input  logic [15:0]                d_addr,
    input  logic                       d_wr,
    input  logic [15:0]                d_wdata,
    output logic                       mem_en,
    output logic                       mem_wr,
    output logic [15:0]                mem_addr,
    output logic [15:0]                mem_wdata,
    input  logic [15:0]                mem_rdata,
    input  logic                       mem_valid,
    output logic                       i_fill_we,
    output logic                       d_fill_we,
    output logic [$clog2(WORDS)-1:0]   fill_word,
    output logic [15:0]                fill_data,
    output logic                       i_tag_we,
    output logic                       d_tag_we,
    output logic                       busy,
    output logic                       stall
);

    localparam int IW = $clog2(WORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t        state_q, state_d;
    logic          gnt_d_q, gnt_d_d;
    logic [15:0]   base_q, base_d;
    logic [IW-1:0] issue_q, issue_d;
    logic [IW-1:0] ret_q, ret_d;
    logic          any_miss, tie, pick_d, fill_act, last_word;
    logic [15:0]   sel_addr;

    assign any_miss = i_miss | d_miss;
    assign tie      = i_miss & d_miss;

`ifdef ARB_ROUND_ROBIN_EN
    // Remembers which side won the most recent tie; reset value means I won last.
    logic last_d_q, last_d_d;

    assign pick_d   = tie ? ~last_d_q : d_miss;
    assign last_d_d = (state_q == IDLE && tie) ? pick_d : last_d_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_d_q <= 1'b0;
        else     last_d_q <= last_d_d;
    end
`else
    assign pick_d = d_miss;
`endif

    assign sel_addr  = pick_d ? d_addr : i_addr;
    assign fill_act  = (state_q != IDLE) && mem_valid;
    assign last_word = fill_act && (ret_q == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_d_q <= 1'b0;
            base_q  <= '0;
            issue_q <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_d_q <= gnt_d_d;
            base_q  <= base_d;
            issue_q <= issue_d;
            ret_q   <= ret_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d_d   = gnt_d_q;
        base_d    = base_q;
        issue_d   = issue_q;
        ret_d     = ret_q;
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        case (state_q)
            IDLE: begin
                if (any_miss) begin
                    state_d = ISSUE;
                    gnt_d_d = pick_d;
                    base_d  = sel_addr & 16'hFFF0;
                    issue_d = '0;
                    ret_d   = '0;
                end else if (d_wr) begin
                    // Write-through store passes straight to memory with no extra cycle.
                    mem_en    = 1'b1;
                    mem_wr    = 1'b1;
                    mem_addr  = d_addr;
                    mem_wdata = d_wdata;
                end
            end
            ISSUE: begin
                mem_en   = 1'b1;
                mem_addr = base_q + (16'(issue_q) << 1);
                issue_d  = issue_q + 1'b1;
                if (issue_q == LAST_IDX) state_d = DRAIN;
            end
            DRAIN: ;
            default: state_d = IDLE;
        endcase

        // Returns may overlap issue, so they are counted independently of the state.
        if (fill_act) ret_d = ret_q + 1'b1;
        if (last_word) state_d = IDLE;
    end

    assign i_fill_we = fill_act & ~gnt_d_q;
    assign d_fill_we = fill_act &  gnt_d_q;
    assign i_tag_we  = last_word & ~gnt_d_q;
    assign d_tag_we  = last_word &  gnt_d_q;
    assign fill_word = fill_act ? ret_q : '0;
    assign fill_data = fill_act ? mem_rdata : '0;
    assign busy      = (state_q != IDLE);
    assign stall     = busy | i_miss | d_miss;

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Self-checking bench for cache_fill_arbiter: directed steps plus randomized
// misses/stores against a cycle-offset model of the fill protocol.
module tb_cache_fill_arbiter;

    localparam int WORDS = 8;
    localparam int LAT   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_miss, d_miss, d_wr;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        mem_en, mem_wr, mem_valid;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        i_fill_we, d_fill_we, i_tag_we, d_tag_we, busy, stall;
    logic [2:0]  fill_word;
    logic [15:0] fill_data;
    logic        xv = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    bit last_d = 1'b0;

    always #5 clk = ~clk;

    cache_fill_arbiter #(.WORDS(WORDS)) dut (
        .clk(clk), .rst(rst),
        .i_miss(i_miss), .i_addr(i_addr),
        .d_miss(d_miss), .d_addr(d_addr),
        .d_wr(d_wr), .d_wdata(d_wdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
        .fill_word(fill_word), .fill_data(fill_data),
        .i_tag_we(i_tag_we), .d_tag_we(d_tag_we),
        .busy(busy), .stall(stall)
    );

    // Memory contents as a function of address.
    function automatic logic [15:0] memf(input logic [15:0] a);
        logic [15:0] p;
        p = a * 16'h9E37;
        return p ^ 16'h5A5A;
    endfunction

    // 4-cycle pipelined memory: a read request returns LAT cycles later.
    logic [3:0]  pv = 4'b0;
    logic [15:0] pa [4];
    always @(posedge clk) begin
        pv    <= {pv[2:0], mem_en & ~mem_wr};
        pa[0] <= mem_addr;
        pa[1] <= pa[0];
        pa[2] <= pa[1];
        pa[3] <= pa[2];
    end
    assign mem_valid = pv[3] | xv;
    assign mem_rdata = pv[3] ? memf(pa[3]) : 16'h1234;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic exp_cyc(input string tag, input bit en, input bit wr,
                           input logic [15:0] addr, input logic [15:0] wdata,
                           input bit ifw, input bit dfw, input int word, input logic [15:0] data,
                           input bit itag, input bit dtag, input bit busy_e, input bit stall_e);
        chk({tag, ".mem_en"}, 16'(mem_en), 16'(en));
        chk({tag, ".mem_wr"}, 16'(mem_wr), 16'(wr));
        if (en) chk({tag, ".mem_addr"}, mem_addr, addr);
        if (en && wr) chk({tag, ".mem_wdata"}, mem_wdata, wdata);
        chk({tag, ".i_fill_we"}, 16'(i_fill_we), 16'(ifw));
        chk({tag, ".d_fill_we"}, 16'(d_fill_we), 16'(dfw));
        if (ifw || dfw) begin
            chk({tag, ".fill_word"}, 16'(fill_word), 16'(word));
            chk({tag, ".fill_data"}, fill_data, data);
        end
        chk({tag, ".i_tag_we"}, 16'(i_tag_we), 16'(itag));
        chk({tag, ".d_tag_we"}, 16'(d_tag_we), 16'(dtag));
        chk({tag, ".busy"}, 16'(busy), 16'(busy_e));
        chk({tag, ".stall"}, 16'(stall), 16'(stall_e));
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_in(input bit im, input logic [15:0] ia, input bit dm,
                          input logic [15:0] da, input bit dw, input logic [15:0] wd);
        i_miss = im; i_addr = ia; d_miss = dm; d_addr = da; d_wr = dw; d_wdata = wd;
    endtask

    task automatic exp_idle(input string tag);
        exp_cyc(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, i_miss | d_miss);
    endtask

    // Called in the detection cycle with the miss inputs already applied and settled;
    // walks the whole fill: issue in offsets 1..WORDS, returns in LAT+1..WORDS+LAT.
    task automatic run_fill(input string tag, input bit is_d, input logic [15:0] a);
        logic [15:0] b;
        b = {a[15:4], 4'h0};
        exp_cyc({tag, ".detect"}, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int k = 1; k <= WORDS + LAT; k++) begin
            bit en, fw, tg;
            tick(); #1;
            en = (k <= WORDS);
            fw = (k > LAT);
            tg = (k == WORDS + LAT);
            exp_cyc($sformatf("%s.k%0d", tag, k), en, 0, b + 16'(2 * (k - 1)), 0,
                    fw & ~is_d, fw & is_d, k - LAT - 1, memf(b + 16'(2 * (k - LAT - 1))),
                    tg & ~is_d, tg & is_d, 1, 1);
        end
    endtask

    function automatic bit tie_winner();
        bit w;
`ifdef ARB_ROUND_ROBIN_EN
        w = ~last_d;
`else
        w = 1'b1;
`endif
        last_d = w;
        return w;
    endfunction

    task automatic tie_pair(input string tag, input logic [15:0] ia, input logic [15:0] da);
        bit w;
        tick(); set_in(1, ia, 1, da, 0, 0); #1;
        w = tie_winner();
        run_fill({tag, ".first"}, w, w ? da : ia);
        tick();
        if (w) d_miss = 1'b0; else i_miss = 1'b0;
        #1;
        run_fill({tag, ".second"}, ~w, w ? ia : da);
        tick(); set_in(0, 0, 0, 0, 0, 0); #1;
        exp_idle({tag, ".done"});
    endtask

    initial begin
        logic [15:0] wd, ra, rb;
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        #1;
        exp_idle("reset");
        tick(); #1; exp_idle("reset_hold");
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick(); #1; exp_idle("idle20");
        end

        tick(); set_in(1, 16'h0126, 0, 0, 0, 0); #1;
        run_fill("imiss", 0, 16'h0126);
        tick(); set_in(0, 0, 0, 0, 0, 0); #1;
        exp_idle("imiss.after");

        tie_pair("tie1", 16'h7A52, 16'h4008);
`ifdef ARB_ROUND_ROBIN_EN
        tie_pair("tie2", 16'h1110, 16'h4008);
`endif

        tick(); set_in(0, 0, 0, 16'h0200, 1, 16'hBEEF); #1;
        exp_cyc("store", 1, 1, 16'h0200, 16'hBEEF, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); set_in(0, 0, 0, 0, 0, 0); #1;
        exp_idle("store.after");

        wd = 16'($urandom);
        tick(); set_in(0, 0, 1, 16'h0030, 1, wd); #1;
        run_fill("stmiss", 1, 16'h0030);
        tick(); d_miss = 1'b0; #1;
        exp_cyc("stmiss.wt", 1, 1, 16'h0030, wd, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); set_in(0, 0, 0, 0, 0, 0); #1;
        exp_idle("stmiss.after");

        // Abort a D fill after three words have come back.
        ra = 16'($urandom);
        tick(); set_in(0, 0, 1, ra, 0, 0); #1;
        for (int k = 1; k <= LAT + 3; k++) tick();
        rst = 1'b1; last_d = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
        #1;
        exp_idle("abort.rst");
        for (int c = 0; c < 2; c++) begin
            tick(); #1; exp_idle("abort.hold");
        end
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick(); xv = c[0]; #1; exp_idle("abort.post");
        end
        xv = 1'b0;

        for (int it = 0; it < 40; it++) begin
            int sc;
            bit dw;
            sc = int'($urandom_range(0, 3));
            ra = 16'($urandom);
            rb = 16'($urandom);
            wd = 16'($urandom);
            dw = 1'($urandom_range(0, 1));
            case (sc)
                0: begin
                    tick(); set_in(0, ra, 0, rb, dw, wd); xv = 1'($urandom_range(0, 1)); #1;
                    exp_cyc("rnd.idle", dw, dw, rb, wd, 0, 0, 0, 0, 0, 0, 0, 0);
                    xv = 1'b0;
                end
                1: begin
                    tick(); set_in(1, ra, 0, rb, 0, 0); #1;
                    run_fill("rnd.i", 0, ra);
                    tick(); set_in(0, 0, 0, 0, 0, 0); #1;
                    exp_idle("rnd.i.after");
                end
                2: begin
                    tick(); set_in(0, ra, 1, rb, dw, wd); #1;
                    run_fill("rnd.d", 1, rb);
                    tick(); d_miss = 1'b0; #1;
                    exp_cyc("rnd.d.after", dw, dw, rb, wd, 0, 0, 0, 0, 0, 0, 0, 0);
                end
                default: tie_pair("rnd.tie", ra, rb);
            endcase
        end

        tick(); set_in(0, 0, 0, 0, 0, 0); #1;
        exp_idle("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
